pulse_stretcher: RTL
====================

// Module: pulse_stretcher
// PURPOSE
//  Converts single-cycle event pulses (e.g. button-press pulses from the edge-detect
//  debounce stage) back into human-visible fixed-width levels for LEDs/buzzer.
//  Every input pulse yields exactly one output pulse of HOLD_CYCLES, separated by at
//  least GAP_CYCLES low. Pulses arriving while busy are queued in a saturating counter.
// PARAMETERS
//  HOLD_CYCLES  4  output high time per event, cycles (>=1)
//  GAP_CYCLES   2  minimum low time between consecutive output pulses, cycles (>=0)
//  PEND_W       4  width of pending-event counter; max queued = 2**PEND_W-1
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  pulse_in   in   1       event input; each cycle sampled high = one event
//  level_out  out  1       stretched output, registered
//  busy       out  1       high whenever state != IDLE
//  pend_cnt   out  PEND_W  events queued, not yet started
//  overflow   out  1       sticky: an event was dropped (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, level_out=0, busy=0, pend_cnt=0,
//    overflow=0, timer=0. Any in-progress or queued events are discarded.
//  - Single timer, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), counts down.
//  - States: IDLE, HOLD, GAP.
//    IDLE: pulse_in=1 -> HOLD, timer=HOLD_CYCLES-1, level_out=1 from next cycle
//          (latency 1 clock from sampling edge to level_out rising).
//    HOLD: level_out=1; timer!=0 -> decrement; timer==0 -> GAP (timer=GAP_CYCLES-1,
//          level_out=0) or, if GAP_CYCLES==0, take the "end of GAP" decision directly.
//    GAP:  level_out=0; timer!=0 -> decrement; timer==0 -> end of GAP decision:
//          pend_cnt>0 -> HOLD, pend_cnt-1; else pulse_in=1 -> HOLD (event consumed
//          directly, pend_cnt stays 0); else -> IDLE.
//  - level_out high exactly HOLD_CYCLES cycles per event; low >= GAP_CYCLES between.
//  - pulse_in=1 in HOLD/GAP (and not consumed per above): pend_cnt+1.
//  - Simultaneous increment and decrement (pulse_in=1 on an end-of-GAP cycle with
//    pend_cnt>0): pend_cnt unchanged.
//  - Saturation: pend_cnt == 2**PEND_W-1 and a new event must be queued -> event
//    dropped, pend_cnt holds; overflow behaviour per CONFIGURATION.
//  - busy = (state != IDLE), decoded from state register, no extra latency.
//  - pend_cnt never wraps; no event is ever counted twice.
// CONFIGURATION
//  PULSE_STRETCH_OVF_EN defined: overflow set to 1 on the cycle after the first
//    dropped event and held until reset.
//  PULSE_STRETCH_OVF_EN undefined: overflow tied to constant 0; no overflow register
//    synthesized. Drop behaviour is identical in both builds.
// TESTING (HOLD=4, GAP=2, PEND_W=4 unless stated; cycle n = rising edge n)
//  1 Single pulse_in at edge 10 -> level_out=1 after edges 10..13 (4 cycles), 0 after
//    edge 14; busy=1 for 6 cycles, back to IDLE after edge 16; pend_cnt=0 throughout.
//  2 pulse_in high 3 consecutive cycles -> pend_cnt peaks at 2; three 4-cycle high
//    pulses separated by exactly 2 low cycles; busy falls after 3rd GAP.
//  3 PEND_W=2, pulse_in high 6 consecutive cycles, macro defined -> pend_cnt saturates
//    at 3, 2 events dropped, overflow=1 and sticky, exactly 4 output pulses.
//  4 Same as 3 with PULSE_STRETCH_OVF_EN undefined -> overflow=0 always, still 4 pulses.
//  5 pulse_in=1 on final GAP cycle with pend_cnt=0 -> HOLD starts next cycle, no IDLE
//    cycle, busy stays 1, level_out gap exactly 2 cycles.
//  6 rst_n low mid-HOLD with pend_cnt=3 -> level_out, busy, pend_cnt, overflow go 0
//    immediately (no clock); after release, no output until a new pulse_in.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into HOLD_CYCLES-wide levels separated by GAP_CYCLES low,
// queueing early events. Define PULSE_STRETCH_OVF_EN to build the sticky overflow flag.
`timescale 1ns/1ps

module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int MAX_T = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              level_q;
  logic              end_gap;
  logic              queue_evt;
  logic              take_pend;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    end_gap   = 1'b0;
    queue_evt = 1'b0;
    take_pend = 1'b0;
    pend_d    = pend_q;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        queue_evt = pulse_in;
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          end_gap = 1'b1;
        end
      end
      GAP: begin
        queue_evt = pulse_in;
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          end_gap = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Queued events take priority; with an empty queue a same-cycle pulse starts HOLD directly.
    if (end_gap) begin
      take_pend = (pend_q != '0);
      if (take_pend || pulse_in) begin
        state_d = HOLD;
        timer_d = HOLD_LOAD;
      end else begin
        state_d = IDLE;
      end
      if (!take_pend) begin
        queue_evt = 1'b0;
      end
    end

    if (take_pend && !queue_evt) begin
      pend_d = pend_q - PEND_W'(1);
    end else if (!take_pend && queue_evt && (pend_q != '1)) begin
      pend_d = pend_q + PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      level_q <= (state_d == HOLD);
    end
  end

`ifdef PULSE_STRETCH_OVF_EN
  logic drop;
  logic ovf_q;

  assign drop = queue_evt && !take_pend && (pend_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign level_out = level_q;
  assign busy      = (state_q != IDLE);
  assign pend_cnt  = pend_q;

endmodule
